// File: rtl/pong_pkg.sv
// pong_pkg
//   Shared types and default geometry for the pong game engine.
//   game_state_t : SERVE / PLAY / POINT / GAMEOVER (encoded 0..3, visible on oState)
//   pos_t        : 12-bit screen coordinate
//   wide_t       : 13-bit working width used for all position sums and compares
//   DEF_*        : default geometry and timing constants
//   centre_of()  : top-left coordinate that centres an object of a given size
package pong_pkg;

  typedef enum logic [1:0] {
    SERVE    = 2'd0,
    PLAY     = 2'd1,
    POINT    = 2'd2,
    GAMEOVER = 2'd3
  } game_state_t;

  typedef logic [11:0] pos_t;
  typedef logic [12:0] wide_t;

  localparam int unsigned DEF_SCREEN_W     = 640;
  localparam int unsigned DEF_SCREEN_H     = 480;
  localparam int unsigned DEF_PADDLE_W     = 20;
  localparam int unsigned DEF_PADDLE_H     = 100;
  localparam int unsigned DEF_BALL_SIZE    = 20;
  localparam int unsigned DEF_PL_X         = 100;
  localparam int unsigned DEF_PR_X         = 500;
  localparam int unsigned DEF_PADDLE_VEL   = 10;
  localparam int unsigned DEF_BALL_VEL     = 3;
  localparam int unsigned DEF_PAUSE_FRAMES = 60;
  localparam int unsigned DEF_WIN_SCORE    = 7;

  function automatic int unsigned centre_of(input int unsigned extent, input int unsigned size);
    return (extent - size) / 2;
  endfunction

endpackage

// File: rtl/pong_sync_edge.sv
// sync_edge
//   Two-flop synchronizer for asynchronous active-low inputs, plus a registered
//   one-cycle pulse on each synchronized falling edge.
//   clk   in  sampling clock
//   rst   in  asynchronous active-high reset (flops reset to the idle-high level)
//   data  in  WIDTH asynchronous inputs
//   level out WIDTH synchronized levels
//   fall  out WIDTH one-cycle pulses, high 3 cycles after an input falls
module sync_edge #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '1;
      sync <= '1;
      prev <= '1;
      fall <= '0;
    end else begin
      meta <= data;
      sync <= meta;
      prev <= sync;
      fall <= prev & ~sync;
    end
  end

  assign level = sync;

endmodule

// File: rtl/pong_game_engine.sv
// pong_game_engine
//   Frame-locked game state for two-player pong. One update per falling edge of
//   vertical sync; all outputs are registers that change only on the cycle
//   after that update.
//   iVGA_CLK                 in   pixel clock
//   iRST                     in   asynchronous active-high reset
//   iVS                      in   vertical sync, active-low, asynchronous
//   pL_moveup .. pR_movedown in   paddle buttons, active-low, asynchronous
//   iStart_n                 in   start/serve button, active-low, asynchronous
//   oPL_ypos, oPR_ypos       out  paddle top y
//   oB_xpos, oB_ypos         out  ball top-left
//   oScoreL, oScoreR         out  scores
//   oState                   out  game state (SERVE/PLAY/POINT/GAMEOVER)
//   oFrame_tick              out  one-cycle pulse on the update cycle
module pong_game_engine
  import pong_pkg::*;
#(
  parameter int unsigned SCREEN_W     = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H     = DEF_SCREEN_H,
  parameter int unsigned PADDLE_W     = DEF_PADDLE_W,
  parameter int unsigned PADDLE_H     = DEF_PADDLE_H,
  parameter int unsigned BALL_SIZE    = DEF_BALL_SIZE,
  parameter int unsigned PL_X         = DEF_PL_X,
  parameter int unsigned PR_X         = DEF_PR_X,
  parameter int unsigned PADDLE_VEL   = DEF_PADDLE_VEL,
  parameter int unsigned BALL_VEL     = DEF_BALL_VEL,
  parameter int unsigned PAUSE_FRAMES = DEF_PAUSE_FRAMES,
  parameter int unsigned WIN_SCORE    = DEF_WIN_SCORE
) (
  input  logic        iVGA_CLK,
  input  logic        iRST,
  input  logic        iVS,
  input  logic        pL_moveup,
  input  logic        pL_movedown,
  input  logic        pR_moveup,
  input  logic        pR_movedown,
  input  logic        iStart_n,
  output logic [11:0] oPL_ypos,
  output logic [11:0] oPR_ypos,
  output logic [11:0] oB_xpos,
  output logic [11:0] oB_ypos,
  output logic [3:0]  oScoreL,
  output logic [3:0]  oScoreR,
  output logic [1:0]  oState,
  output logic        oFrame_tick
);

  localparam wide_t SW         = wide_t'(SCREEN_W);
  localparam wide_t SH         = wide_t'(SCREEN_H);
  localparam wide_t PH         = wide_t'(PADDLE_H);
  localparam wide_t BSZ        = wide_t'(BALL_SIZE);
  localparam wide_t BVEL       = wide_t'(BALL_VEL);
  localparam wide_t PVEL       = wide_t'(PADDLE_VEL);
  localparam wide_t PADDLE_MAX = wide_t'(SCREEN_H - PADDLE_H);
  localparam wide_t BALL_X_MAX = wide_t'(SCREEN_W - BALL_SIZE);
  localparam wide_t BALL_Y_MAX = wide_t'(SCREEN_H - BALL_SIZE);
  localparam wide_t PL_FACE    = wide_t'(PL_X + PADDLE_W);
  localparam wide_t PR_EDGE    = wide_t'(PR_X);
  localparam wide_t PR_FACE    = wide_t'(PR_X - BALL_SIZE);

  localparam pos_t PADDLE_RST = pos_t'(centre_of(SCREEN_H, PADDLE_H));
  localparam pos_t BALL_X_C   = pos_t'(centre_of(SCREEN_W, BALL_SIZE));
  localparam pos_t BALL_Y_C   = pos_t'(centre_of(SCREEN_H, BALL_SIZE));

  localparam int unsigned CNT_W = $clog2(PAUSE_FRAMES + 1);
  localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_FRAMES - 1);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  // Input synchronization
  logic       vs_level, vs_fall;
  logic       start_level, start_fall;
  logic [3:0] btn_level, btn_fall;
  logic       unused_sync;

  sync_edge #(.WIDTH(1)) u_vs_sync (
    .clk(iVGA_CLK), .rst(iRST), .data(iVS), .level(vs_level), .fall(vs_fall)
  );

  sync_edge #(.WIDTH(1)) u_start_sync (
    .clk(iVGA_CLK), .rst(iRST), .data(iStart_n), .level(start_level), .fall(start_fall)
  );

  sync_edge #(.WIDTH(4)) u_btn_sync (
    .clk(iVGA_CLK), .rst(iRST),
    .data({pL_moveup, pL_movedown, pR_moveup, pR_movedown}),
    .level(btn_level), .fall(btn_fall)
  );

  assign unused_sync = ^{vs_level, start_level, btn_fall};

  logic tick;
  logic pl_up, pl_dn, pr_up, pr_dn;

  assign tick  = vs_fall;
  assign pl_up = ~btn_level[3];
  assign pl_dn = ~btn_level[2];
  assign pr_up = ~btn_level[1];
  assign pr_dn = ~btn_level[0];

  // Game state
  game_state_t      state;
  pos_t             pl_y, pr_y, ball_x, ball_y;
  logic             dx, dy;
  logic [3:0]       score_l, score_r;
  logic [CNT_W-1:0] pause_cnt;
  logic             start_pending;

  function automatic pos_t paddle_next(input pos_t y, input logic up, input logic dn);
    wide_t w;
    w = wide_t'(y);
    paddle_next = y;
    if (up && !dn) begin
      paddle_next = (w < PVEL) ? '0 : pos_t'(w - PVEL);
    end else if (dn && !up) begin
      paddle_next = (w + PVEL > PADDLE_MAX) ? pos_t'(PADDLE_MAX) : pos_t'(w + PVEL);
    end
  endfunction

  pos_t pl_next, pr_next;

  assign pl_next = paddle_next(pl_y, pl_up, pl_dn);
  assign pr_next = paddle_next(pr_y, pr_up, pr_dn);

  // Ball step for a PLAY tick, using pre-update paddle positions
  wide_t bx, by, plw, prw, nx, ny;
  logic  ov_l, ov_r, dx_next, dy_next, left_scores, right_scores;

  always_comb begin
    bx  = wide_t'(ball_x);
    by  = wide_t'(ball_y);
    plw = wide_t'(pl_y);
    prw = wide_t'(pr_y);
    ov_l = (by + BSZ > plw) && (by < plw + PH);
    ov_r = (by + BSZ > prw) && (by < prw + PH);

    ny      = by;
    dy_next = dy;
    if (!dy && (by < BVEL)) begin
      ny      = '0;
      dy_next = 1'b1;
    end else if (dy && (by + BSZ + BVEL >= SH)) begin
      ny      = BALL_Y_MAX;
      dy_next = 1'b0;
    end else if (dy) begin
      ny = by + BVEL;
    end else begin
      ny = by - BVEL;
    end

    nx           = bx;
    dx_next      = dx;
    left_scores  = 1'b0;
    right_scores = 1'b0;
    if (!dx && (bx >= PL_FACE) && (bx - BVEL <= PL_FACE) && ov_l) begin
      nx      = PL_FACE;
      dx_next = 1'b1;
    end else if (dx && (bx + BSZ <= PR_EDGE) && (bx + BSZ + BVEL >= PR_EDGE) && ov_r) begin
      nx      = PR_FACE;
      dx_next = 1'b0;
    end else if (!dx && (bx < BVEL)) begin
      nx           = '0;
      right_scores = 1'b1;
    end else if (dx && (bx + BSZ + BVEL >= SW)) begin
      nx          = BALL_X_MAX;
      left_scores = 1'b1;
    end else if (dx) begin
      nx = bx + BVEL;
    end else begin
      nx = bx - BVEL;
    end
  end

  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      state         <= SERVE;
      pl_y          <= PADDLE_RST;
      pr_y          <= PADDLE_RST;
      ball_x        <= BALL_X_C;
      ball_y        <= BALL_Y_C;
      dx            <= 1'b1;
      dy            <= 1'b1;
      score_l       <= '0;
      score_r       <= '0;
      pause_cnt     <= '0;
      start_pending <= 1'b0;
    end else begin
      // A press landing on a tick cycle survives to the following tick.
      if (start_fall) begin
        start_pending <= 1'b1;
      end else if (tick) begin
        start_pending <= 1'b0;
      end

      if (tick) begin
        if (state != GAMEOVER) begin
          pl_y <= pl_next;
          pr_y <= pr_next;
        end

        case (state)
          SERVE: begin
            ball_x <= BALL_X_C;
            ball_y <= BALL_Y_C;
            if (start_pending) state <= PLAY;
          end
          PLAY: begin
            ball_x <= pos_t'(nx);
            ball_y <= pos_t'(ny);
            dx     <= dx_next;
            dy     <= dy_next;
            if (left_scores || right_scores) begin
              state     <= POINT;
              pause_cnt <= '0;
              if (left_scores) score_l <= score_l + 4'd1;
              else             score_r <= score_r + 4'd1;
            end
          end
          POINT: begin
            if (pause_cnt == PAUSE_LAST) begin
              if ((score_l == WIN) || (score_r == WIN)) begin
                state <= GAMEOVER;
              end else begin
                // A miss leaves dx unchanged, so it already points at the loser.
                state  <= SERVE;
                ball_x <= BALL_X_C;
                ball_y <= BALL_Y_C;
                dy     <= 1'b1;
              end
            end else begin
              pause_cnt <= pause_cnt + 1'b1;
            end
          end
          GAMEOVER: begin
            if (start_pending) begin
              score_l <= '0;
              score_r <= '0;
              ball_x  <= BALL_X_C;
              ball_y  <= BALL_Y_C;
              state   <= SERVE;
            end
          end
          default: state <= SERVE;
        endcase
      end
    end
  end

  assign oPL_ypos    = pl_y;
  assign oPR_ypos    = pr_y;
  assign oB_xpos     = ball_x;
  assign oB_ypos     = ball_y;
  assign oScoreL     = score_l;
  assign oScoreR     = score_r;
  assign oState      = state;
  assign oFrame_tick = tick;

endmodule
